// File: rtl/raggedstone_spinn_aer_if_mode_ctrl_if.sv
// Configuration handshake bundle: the mode controller proposes a mode, the
// configuration logic acknowledges it.
interface raggedstone_spinn_aer_if_mode_ctrl_if #(
    parameter int MODE_W = 2
);
    logic              cfg_req;
    logic [MODE_W-1:0] cfg_mode;
    logic              cfg_ack;

    modport master (output cfg_req, output cfg_mode, input cfg_ack);
    modport slave  (input cfg_req, input cfg_mode, output cfg_ack);
endinterface

// File: rtl/raggedstone_spinn_aer_if_mode_ctrl.sv
// Front-panel mode controller: short press steps and commits the mode over a
// req/ack handshake, long press emits a one-cycle abort/apply pulse.
module raggedstone_spinn_aer_if_mode_ctrl #(
    parameter int unsigned LONG_PRESS_CONST = 24'h7fffff,
    parameter int          MODE_W           = 2,
    parameter int          NUM_MODES        = 4,
    parameter int          RESET_MODE       = 0
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  pb_debounced,
    raggedstone_spinn_aer_if_mode_ctrl_if.master  cfg,
    output logic [MODE_W-1:0]                     mode,
    output logic                                  long_press,
    output logic                                  busy_led
);
    localparam int CNT_W = $clog2(LONG_PRESS_CONST + 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(LONG_PRESS_CONST - 1);
    localparam logic [CNT_W-1:0]  HOLD_MAX  = CNT_W'(LONG_PRESS_CONST);
    localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);
    localparam logic [MODE_W-1:0] MODE_RST  = MODE_W'(RESET_MODE);

    typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  hold_reg;
    logic              pb_q_reg;
    logic              armed_reg;
    logic              cfg_req_reg;
    logic [MODE_W-1:0] cfg_mode_reg;
    logic [MODE_W-1:0] mode_reg;
    logic              long_press_reg;
    logic [MODE_W-1:0] mode_next;
    logic              press;

    assign mode_next = (mode_reg == MODE_LAST) ? '0 : mode_reg + MODE_W'(1);
    // armed_reg blocks a button already held across reset release until it
    // has been seen high once.
    assign press     = armed_reg && pb_q_reg && !pb_debounced;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            hold_reg       <= '0;
            pb_q_reg       <= 1'b1;
            armed_reg      <= 1'b0;
            cfg_req_reg    <= 1'b0;
            cfg_mode_reg   <= MODE_RST;
            mode_reg       <= MODE_RST;
            long_press_reg <= 1'b0;
        end else begin
            pb_q_reg       <= pb_debounced;
            long_press_reg <= 1'b0;
            if (pb_debounced) begin
                armed_reg <= 1'b1;
            end
            if (cfg_req_reg && cfg.cfg_ack) begin
                mode_reg    <= cfg_mode_reg;
                cfg_req_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (press) begin
                        state_reg <= PRESSED;
                        hold_reg  <= CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (pb_debounced) begin
                        state_reg <= IDLE;
                        hold_reg  <= '0;
                        // A short press while a request is outstanding is dropped.
                        if (!cfg_req_reg) begin
                            cfg_mode_reg <= mode_next;
                            cfg_req_reg  <= 1'b1;
                        end
                    end else if (hold_reg == HOLD_LAST) begin
                        long_press_reg <= 1'b1;
                        state_reg      <= LONG;
                        cfg_req_reg    <= 1'b0;
                    end else if (hold_reg != HOLD_MAX) begin
                        hold_reg <= hold_reg + CNT_W'(1);
                    end
                end
                LONG: begin
                    if (pb_debounced) begin
                        state_reg <= IDLE;
                        hold_reg  <= '0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    hold_reg  <= '0;
                end
            endcase
        end
    end

    assign cfg.cfg_req  = cfg_req_reg;
    assign cfg.cfg_mode = cfg_mode_reg;
    assign mode         = mode_reg;
    assign long_press   = long_press_reg;
    assign busy_led     = cfg_req_reg;
endmodule
